// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered long-latency results,
// with a starvation bound on the buffered path and a busy scoreboard for RAW hazard detection.
module rf_wb_arbiter #(
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p_valid,
   output logic        p_ready,
   input  logic [4:0]  p_waddr,
   input  logic [31:0] p_wdata,
   input  logic        l_valid,
   output logic        l_ready,
   input  logic [4:0]  l_waddr,
   input  logic [31:0] l_wdata,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   output logic        hazard,
   output logic [31:0] busy,
   output logic        rf_wen,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata
);
   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          mem_d [DEPTH];
   logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [SW-1:0]   starve_q, starve_d;
   logic [31:0]     busy_q, busy_d;
   logic            rf_wen_q, rf_wen_d, src_l_q, src_l_d;
   logic [4:0]      rf_waddr_q, rf_waddr_d;
   logic [31:0]     rf_wdata_q, rf_wdata_d;

   logic   empty, full, force_l, grant_p, grant_h, push;
   entry_t head;

   always_comb begin
      empty   = (wr_ptr_q == rd_ptr_q);
      full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      head    = mem_q[rd_ptr_q[AW-1:0]];
      force_l = !empty && (starve_q == SW'(STARVE_MAX));
      grant_p = p_valid && !force_l;
      grant_h = !empty && (!p_valid || force_l);
      push    = l_valid && l_ready;
   end

   // A full FIFO can still accept when its head drains in the same cycle.
   assign p_ready  = !force_l;
   assign l_ready  = !full || grant_h;
   assign busy     = busy_q;
   assign hazard   = ((rs1 != 5'd0) && busy_q[rs1]) || ((rs2 != 5'd0) && busy_q[rs2]);
   assign rf_wen   = rf_wen_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q[AW-1:0]] = '{addr: l_waddr, data: l_wdata};
         wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      end
      if (grant_h)
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);

      starve_d = starve_q;
      if (empty || grant_h)
         starve_d = '0;
      else if (grant_p && (starve_q != SW'(STARVE_MAX)))
         starve_d = starve_q + SW'(1);

      rf_wen_d   = 1'b0;
      src_l_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (grant_h) begin
         rf_waddr_d = head.addr;
         rf_wdata_d = head.data;
         rf_wen_d   = (head.addr != 5'd0);
         src_l_d    = 1'b1;
      end else if (grant_p) begin
         rf_waddr_d = p_waddr;
         rf_wdata_d = p_wdata;
         rf_wen_d   = (p_waddr != 5'd0);
      end

      // Clear on the commit edge first so a same-cycle re-issue keeps the bit set.
      busy_d = busy_q;
      if (rf_wen_q && src_l_q)
         busy_d[rf_waddr_q] = 1'b0;
      if (issue_valid && (issue_rd != 5'd0))
         busy_d[issue_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q      <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         starve_q   <= '0;
         busy_q     <= '0;
         rf_wen_q   <= 1'b0;
         src_l_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         starve_q   <= starve_d;
         busy_q     <= busy_d;
         rf_wen_q   <= rf_wen_d;
         src_l_q    <= src_l_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: a queue-based reference model predicts writes and
// handshake/scoreboard outputs; a negedge monitor checks every asserted rf write.
module tb_rf_wb_arbiter;
   localparam int DEPTH      = 2;
   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0, rst = 1'b1;
   logic        p_valid = 0, l_valid = 0, issue_valid = 0;
   logic [4:0]  p_waddr = 0, l_waddr = 0, issue_rd = 0, rs1 = 0, rs2 = 0;
   logic [31:0] p_wdata = 0, l_wdata = 0;
   logic        p_ready, l_ready, hazard, rf_wen;
   logic [31:0] busy, rf_wdata;
   logic [4:0]  rf_waddr;

   rf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst),
      .p_valid(p_valid), .p_ready(p_ready), .p_waddr(p_waddr), .p_wdata(p_wdata),
      .l_valid(l_valid), .l_ready(l_ready), .l_waddr(l_waddr), .l_wdata(l_wdata),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
      .hazard(hazard), .busy(busy),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   wr_t         mq[$];
   wr_t         exp_q[$];
   int          mstarve = 0;
   logic [31:0] mbusy = 0;
   logic        mclr_v = 0;
   logic [4:0]  mclr_a = 0;
   int          n_vec = 0, n_err = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : monitor
      wr_t e;
      if (!rst && rf_wen !== 1'b0) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_write: got wen=%b addr %0d, expected no write at %0t",
                     rf_wen, rf_waddr, $time);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", {27'd0, rf_waddr}, {27'd0, e.a});
            chk("wr_data", rf_wdata, e.d);
         end
      end
   end

   // One clock cycle: drive at negedge, check combinational outputs, advance the model.
   task automatic cyc(logic pv, logic [4:0] pa, logic [31:0] pd,
                      logic lv, logic [4:0] la, logic [31:0] ld,
                      logic iv, logic [4:0] ir, logic [4:0] r1, logic [4:0] r2);
      bit  empty, full, frc, gh, gp, lrdy, hz, nclr;
      wr_t h;
      p_valid = pv; p_waddr = pa; p_wdata = pd;
      l_valid = lv; l_waddr = la; l_wdata = ld;
      issue_valid = iv; issue_rd = ir; rs1 = r1; rs2 = r2;
      #1;
      empty = (mq.size() == 0);
      full  = (mq.size() == DEPTH);
      frc   = !empty && (mstarve == STARVE_MAX);
      gh    = !empty && (!pv || frc);
      gp    = pv && !frc;
      lrdy  = !full || gh;
      hz    = ((r1 != 0) && mbusy[r1]) || ((r2 != 0) && mbusy[r2]);
      chk("p_ready", {31'd0, p_ready}, {31'd0, !frc});
      chk("l_ready", {31'd0, l_ready}, {31'd0, lrdy});
      chk("hazard",  {31'd0, hazard},  {31'd0, hz});
      chk("busy",    busy, mbusy);
      if (gp && pa != 0) exp_q.push_back('{pa, pd});
      nclr = 0;
      h    = '{5'd0, 32'd0};
      if (gh) begin
         h = mq.pop_front();
         if (h.a != 0) begin
            exp_q.push_back(h);
            nclr = 1;
         end
      end
      if (empty || gh) mstarve = 0;
      else if (gp && mstarve < STARVE_MAX) mstarve++;
      if (lv && lrdy) mq.push_back('{la, ld});
      if (mclr_v) mbusy[mclr_a] = 1'b0;
      if (iv && ir != 0) mbusy[ir] = 1'b1;
      mclr_v = nclr;
      mclr_a = h.a;
      @(negedge clk);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      p_valid = 0; l_valid = 0; issue_valid = 0;
      #1;
      chk("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
      chk("rst_busy", busy, 32'd0);
      mq.delete(); exp_q.delete();
      mstarve = 0; mbusy = 0; mclr_v = 0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_l_ready", {31'd0, l_ready}, 32'd1);
      chk("rst_p_ready", {31'd0, p_ready}, 32'd1);
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("init_rf_wen",   {31'd0, rf_wen}, 32'd0);
      chk("init_rf_waddr", {27'd0, rf_waddr}, 32'd0);
      chk("init_rf_wdata", rf_wdata, 32'd0);
      chk("init_busy",     busy, 32'd0);
      chk("init_l_ready",  {31'd0, l_ready}, 32'd1);
      rst = 1'b0;
      @(negedge clk);

      // P only, back-to-back.
      for (int i = 0; i < 10; i++) cyc(1, 5, 32'hAAAA + i, 0, 0, 0, 0, 0, 0, 0);
      idle(2);

      // L only: issue x7, push x7, hazard visible until commit.
      cyc(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
      cyc(0, 0, 0, 1, 7, 32'h1234, 0, 0, 7, 0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);

      // Starvation: head x9 waits behind continuous P traffic.
      cyc(1, 4, 32'h40, 1, 9, 32'h99, 1, 9, 0, 0);
      for (int i = 0; i < 7; i++) cyc(1, 6, 32'h600 + i, 0, 0, 0, 0, 0, 9, 0);
      idle(2);

      // Full FIFO under continuous P.
      for (int i = 0; i < 8; i++)
         cyc(1, 10, 32'hB00 + i, 1, 5'(11 + i), 32'hC00 + i, 0, 0, 0, 0);
      idle(4);

      // x0 result and same-cycle set/clear on x3.
      cyc(0, 0, 0, 1, 0, 32'hDEAD, 0, 0, 0, 0);
      idle(3);
      cyc(0, 0, 0, 1, 3, 32'h33, 1, 3, 3, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
      cyc(0, 0, 0, 0, 0, 0, 1, 3, 3, 0);
      idle(2);

      // Reset mid-operation with two FIFO entries and busy = 0x88.
      cyc(1, 1, 32'h1, 1, 3, 32'h3, 1, 3, 0, 0);
      cyc(1, 2, 32'h2, 1, 7, 32'h7, 1, 7, 0, 0);
      do_reset();

      // Randomized traffic with one reset in the middle.
      for (int i = 0; i < 800; i++) begin
         if (i == 400) do_reset();
         cyc($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
             $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
             $urandom_range(0, 9) < 3, 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end
      idle(8);
      chk("drain_exp_q", exp_q.size(), 32'd0);
      chk("drain_busy_model_fifo", mq.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
